// File: rtl/rr_arb8_sel.sv
// Eight-way round-robin arbiter driving a registered mux select with a valid/ready output; sel/out_vld one cycle after req.
// Stalls hold sel, out_vld and ptr unchanged; handshakes re-arbitrate back-to-back with no bubble.
module rr_arb8_sel #(
  parameter int N_REQ = 8,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out_vld,
  input  logic             out_rdy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] sel_oh;
  logic       hs;
  logic [3:0] pick_idle;
  logic [3:0] pick_next;

  // Returns {found, index}; scanning downward lets the smallest offset from start win.
  function automatic logic [3:0] pick(input logic [7:0] mask, input logic [2:0] start);
    logic [3:0] r;
    logic [2:0] idx;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    sel_oh    = 8'(1) << sel_q;
    hs        = (state_q == BUSY) && out_rdy;
    gnt       = hs ? N_REQ'(sel_oh) : '0;
    pick_idle = pick(8'(req), ptr_q);
    // The just-served index is masked so a requester still high after its gnt is not granted twice.
    pick_next = pick(8'(req) & ~sel_oh, sel_q + 3'd1);
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[3]) begin
          sel_d   = pick_idle[2:0];
          state_d = BUSY;
        end
      end
      default: begin
        if (out_rdy) begin
          ptr_d = sel_q + 3'd1;
          if (pick_next[3]) sel_d = pick_next[2:0];
          else              state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_vld = (state_q == BUSY);
  assign sel     = {{(SEL_W-3){1'b0}}, sel_q};

endmodule

// File: tb/tb_rr_arb8_sel.sv
// Directed bench for rr_arb8_sel: reset, single request, rotation, backpressure, wrap-around, reset mid-transfer.
module tb_rr_arb8_sel;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [3:0] sel;
  logic       out_vld;
  logic       out_rdy;

  int checks = 0;
  int errors = 0;

  rr_arb8_sel dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .out_vld (out_vld),
    .out_rdy (out_rdy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 8'h00;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req     = 8'hFF;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sel !== 4'd0 || out_vld !== 1'b0 || gnt !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: sel=%0d vld=%b gnt=%h, want sel=0 vld=0 gnt=00", i, sel, out_vld, gnt);
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (sel !== 4'd0 || out_vld !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: sel=%0d vld=%b, want sel=0 vld=1", sel, out_vld);
    end
  endtask

  task automatic test_single();
    do_reset();
    req     = 8'h20;
    out_rdy = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h00) begin
      errors++;
      $display("FAIL single_idle_gnt: gnt=%h, want 00", gnt);
    end
    step();
    checks++;
    if (sel !== 4'd5 || out_vld !== 1'b1 || gnt !== 8'h20) begin
      errors++;
      $display("FAIL single_sel: sel=%0d vld=%b gnt=%h, want sel=5 vld=1 gnt=20", sel, out_vld, gnt);
    end
    req = 8'h00;
    step();
    checks++;
    if (out_vld !== 1'b0 || sel !== 4'd5 || gnt !== 8'h00 || dut.ptr_q !== 3'd6) begin
      errors++;
      $display("FAIL single_done: vld=%b sel=%0d gnt=%h ptr=%0d, want vld=0 sel=5 gnt=00 ptr=6",
               out_vld, sel, gnt, dut.ptr_q);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_gnt;
    do_reset();
    req     = 8'hFF;
    out_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      exp_gnt = 8'h01 << (i % 8);
      checks++;
      if (sel !== 4'(i % 8) || out_vld !== 1'b1 || gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rotation step%0d: sel=%0d vld=%b gnt=%h, want sel=%0d vld=1 gnt=%h",
                 i, sel, out_vld, gnt, i % 8, exp_gnt);
      end
      req = ~exp_gnt;
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    req     = 8'h0A;
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 2) req = 8'h0B;
      checks++;
      if (sel !== 4'd1 || out_vld !== 1'b1 || gnt !== 8'h00) begin
        errors++;
        $display("FAIL bp_stall cyc%0d: sel=%0d vld=%b gnt=%h, want sel=1 vld=1 gnt=00", i, sel, out_vld, gnt);
      end
    end
    out_rdy = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h02) begin
      errors++;
      $display("FAIL bp_gnt: gnt=%h, want 02", gnt);
    end
    req = 8'h09;
    step();
    checks++;
    if (sel !== 4'd3 || out_vld !== 1'b1 || gnt !== 8'h08) begin
      errors++;
      $display("FAIL bp_next: sel=%0d vld=%b gnt=%h, want sel=3 vld=1 gnt=08", sel, out_vld, gnt);
    end
    req = 8'h01;
    step();
    checks++;
    if (sel !== 4'd0 || gnt !== 8'h01) begin
      errors++;
      $display("FAIL bp_wrap_low: sel=%0d gnt=%h, want sel=0 gnt=01", sel, gnt);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    req     = 8'h40;
    out_rdy = 1'b1;
    step();
    req = 8'h00;
    step();
    checks++;
    if (out_vld !== 1'b0 || dut.ptr_q !== 3'd7) begin
      errors++;
      $display("FAIL wrap_ptr7: vld=%b ptr=%0d, want vld=0 ptr=7", out_vld, dut.ptr_q);
    end
    req = 8'h81;
    step();
    checks++;
    if (sel !== 4'd7 || gnt !== 8'h80 || dut.ptr_q !== 3'd7) begin
      errors++;
      $display("FAIL wrap_first: sel=%0d gnt=%h ptr=%0d, want sel=7 gnt=80 ptr=7", sel, gnt, dut.ptr_q);
    end
    req = 8'h01;
    step();
    checks++;
    if (sel !== 4'd0 || gnt !== 8'h01 || out_vld !== 1'b1 || dut.ptr_q !== 3'd0) begin
      errors++;
      $display("FAIL wrap_second: sel=%0d gnt=%h vld=%b ptr=%0d, want sel=0 gnt=01 vld=1 ptr=0",
               sel, gnt, out_vld, dut.ptr_q);
    end
    req = 8'h00;
    step();
    checks++;
    if (out_vld !== 1'b0 || dut.ptr_q !== 3'd1) begin
      errors++;
      $display("FAIL wrap_ptr1: vld=%b ptr=%0d, want vld=0 ptr=1", out_vld, dut.ptr_q);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req     = 8'h10;
    out_rdy = 1'b0;
    step();
    checks++;
    if (sel !== 4'd4 || out_vld !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: sel=%0d vld=%b, want sel=4 vld=1", sel, out_vld);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel !== 4'd0 || out_vld !== 1'b0 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL mid_async: sel=%0d vld=%b gnt=%h, want sel=0 vld=0 gnt=00", sel, out_vld, gnt);
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (gnt[4] !== 1'b0 || out_vld !== 1'b0) begin
        errors++;
        $display("FAIL mid_hold cyc%0d: gnt=%h vld=%b, want gnt=00 vld=0", i, gnt, out_vld);
      end
    end
    req   = 8'h00;
    rst_n = 1'b1;
    step();
    checks++;
    if (out_vld !== 1'b0 || dut.ptr_q !== 3'd0) begin
      errors++;
      $display("FAIL mid_after: vld=%b ptr=%0d, want vld=0 ptr=0", out_vld, dut.ptr_q);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 8'h00;
    out_rdy = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
